// File: rtl/conf_loader_if.sv
// Memory read bus and configuration stream shared by conf_loader and its
// environment. master = the loader; slave = memory / CGRA chain side.
interface conf_loader_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // OBI-style single-outstanding read bus
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  // configuration word stream towards the CGRA chain
  logic [DATA_W-1:0] conf_data;
  logic              conf_valid;
  logic              conf_ready;

  modport master (
    output mem_req, mem_addr, conf_data, conf_valid,
    input  mem_gnt, mem_rvalid, mem_rdata, conf_ready
  );

  modport slave (
    input  mem_req, mem_addr, conf_data, conf_valid,
    output mem_gnt, mem_rvalid, mem_rdata, conf_ready
  );
endinterface

// File: rtl/conf_loader.sv
// Configuration fetch engine: reads a bitstream word by word from memory
// (one read outstanding) and streams it to the CGRA configuration chain,
// ending every completed load with a one-cycle conf_done_o pulse.
// Optional feature macro: CONF_LOADER_CHECKSUM_EN -- the last word of the
// bitstream is an XOR checksum of the payload; it is not streamed and a
// mismatch is reported on conf_err_o.
module conf_loader #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              conf_change_i,
  input  logic [ADDR_W-1:0] conf_addr_i,
  input  logic [CNT_W-1:0]  conf_words_i,
  conf_loader_if.master     bus,
  output logic              conf_done_o,
  output logic              busy_o
`ifdef CONF_LOADER_CHECKSUM_EN
  ,
  output logic              conf_err_o
`endif
);

  typedef enum logic [2:0] {IDLE, REQ, RESP, PUSH, DONE} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] data_q, data_d;
  // abort: a restart arrived while a read was in flight; its data is dropped
  logic              abort_q, abort_d;
  logic              launch;
  logic              last;
`ifdef CONF_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              err_q, err_d;
`endif

  assign last = (idx_q == cnt_q - CNT_W'(1));

  // Next-state logic: conf_change_i always relatches the descriptor at once;
  // the FSM only jumps to the new load when no read is left in flight.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    data_d  = data_q;
    abort_d = abort_q;
    launch  = 1'b0;
`ifdef CONF_LOADER_CHECKSUM_EN
    acc_d   = acc_q;
    err_d   = err_q;
`endif

    if (conf_change_i) begin
      base_d = conf_addr_i;
      cnt_d  = conf_words_i;
      idx_d  = '0;
`ifdef CONF_LOADER_CHECKSUM_EN
      acc_d  = '0;
      err_d  = 1'b0;
`endif
    end

    case (state_q)
      IDLE: if (conf_change_i) launch = 1'b1;
      REQ: begin
        // the request already on the bus must complete before restarting
        if (conf_change_i) abort_d = 1'b1;
        if (bus.mem_gnt) state_d = RESP;
      end
      RESP: begin
        if (conf_change_i) abort_d = 1'b1;
        if (bus.mem_rvalid) begin
          if (abort_q || conf_change_i) launch = 1'b1;
`ifdef CONF_LOADER_CHECKSUM_EN
          else if (last) begin
            err_d   = (acc_q != bus.mem_rdata);
            state_d = DONE;
          end
`endif
          else begin
            data_d  = bus.mem_rdata;
            state_d = PUSH;
          end
        end
      end
      PUSH: begin
        // restart drops the held word without a handshake
        if (conf_change_i) launch = 1'b1;
        else if (bus.conf_ready) begin
          idx_d = idx_q + CNT_W'(1);
`ifdef CONF_LOADER_CHECKSUM_EN
          // the checksum word is consumed in RESP, so a pushed word is never last
          acc_d   = acc_q ^ data_q;
          state_d = REQ;
`else
          state_d = last ? DONE : REQ;
`endif
        end
      end
      DONE: begin
        if (conf_change_i) launch = 1'b1;
        else state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (launch) begin
      abort_d = 1'b0;
      state_d = (cnt_d == '0) ? DONE : REQ;
    end
  end

  // State and datapath registers; the request address is frozen on entry to
  // REQ so a restart cannot disturb a request that is waiting for its grant.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      base_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      abort_q <= 1'b0;
`ifdef CONF_LOADER_CHECKSUM_EN
      acc_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      abort_q <= abort_d;
`ifdef CONF_LOADER_CHECKSUM_EN
      acc_q   <= acc_d;
      err_q   <= err_d;
`endif
      if (state_d == REQ && state_q != REQ)
        addr_q <= base_d + (ADDR_W'(idx_d) << 2);
    end
  end

  assign bus.mem_req    = (state_q == REQ);
  assign bus.mem_addr   = addr_q;
  assign bus.conf_valid = (state_q == PUSH);
  assign bus.conf_data  = data_q;
  assign conf_done_o    = (state_q == DONE);
  assign busy_o         = (state_q != IDLE);
`ifdef CONF_LOADER_CHECKSUM_EN
  assign conf_err_o     = err_q;
`endif

endmodule

// File: tb/tb_conf_loader.sv
// Directed bench for conf_loader: a per-cycle memory / chain model driven at
// the falling edge, with logs of granted addresses and accepted words.
module tb_conf_loader;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              conf_change = 1'b0;
  logic [ADDR_W-1:0] conf_addr = '0;
  logic [CNT_W-1:0]  conf_words = '0;
  logic              conf_done;
  logic              busy;
`ifdef CONF_LOADER_CHECKSUM_EN
  logic              conf_err;
  logic              err_at_done;
`endif

  conf_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  conf_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .conf_change_i (conf_change),
    .conf_addr_i   (conf_addr),
    .conf_words_i  (conf_words),
    .bus           (bus),
    .conf_done_o   (conf_done),
    .busy_o        (busy)
`ifdef CONF_LOADER_CHECKSUM_EN
    ,
    .conf_err_o    (conf_err)
`endif
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0, n_err = 0;
  int cyc = 0;
  int n_done, done_cyc, hs_cyc, chg_cyc, n_busy, n_req;
  int addr_bad, hold_bad, req_in_hold;
  int gnt_dly, req_wait, rv_extra, rv_cnt, hold_left, rs_mode;
  logic [31:0] addr_log[$];
  logic [31:0] data_log[$];
  logic [31:0] rv_data, held_addr, hold_data, cks_word;
  bit          hold_set, chg_req;
  logic [31:0] chg_addr;
  logic [15:0] chg_words;
  logic [31:0] rs_addr;
  logic [15:0] rs_words;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] memword(input logic [31:0] a);
    case (a)
      32'h3000: return 32'h0000_00A5;
      32'h3004: return 32'h0000_000F;
      32'h3008: return cks_word;
      default:  return a ^ 32'h5A5A_0000;
    endcase
  endfunction

  task automatic clear();
    n_done = 0; done_cyc = 0; hs_cyc = 0; chg_cyc = 0; n_busy = 0; n_req = 0;
    addr_bad = 0; hold_bad = 0; req_in_hold = 0;
    gnt_dly = 0; req_wait = 0; rv_extra = 0; rv_cnt = 0; hold_left = 0; rs_mode = 0;
    hold_set = 1'b0; chg_req = 1'b0;
    addr_log.delete(); data_log.delete();
  endtask

  // One clock cycle: observe DUT at the falling edge and drive inputs for
  // the coming rising edge.
  task automatic step();
    @(negedge clk_i);
    cyc++;
    conf_change = chg_req;
    if (chg_req) begin
      conf_addr = chg_addr; conf_words = chg_words; chg_cyc = cyc; chg_req = 1'b0;
    end
    if (conf_done) begin
      n_done++;
      if (n_done == 1) done_cyc = cyc;
`ifdef CONF_LOADER_CHECKSUM_EN
      err_at_done = conf_err;
`endif
    end
    if (busy) n_busy++;
    // read data returns rv_extra+1 cycles after the grant
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    if (rv_cnt == 1) begin bus.mem_rvalid = 1'b1; bus.mem_rdata = rv_data; end
    if (rv_cnt > 0) rv_cnt--;
    // configuration chain
    bus.conf_ready = 1'b0;
    if (bus.conf_valid) begin
      if (rs_mode == 2) begin
        chg_req = 1'b1; chg_addr = rs_addr; chg_words = rs_words; rs_mode = 0;
      end
      if (hold_left > 0) begin
        hold_left--;
        if (hold_set && bus.conf_data !== hold_data) hold_bad++;
        hold_data = bus.conf_data; hold_set = 1'b1;
        if (bus.mem_req) req_in_hold++;
      end else begin
        bus.conf_ready = 1'b1;
        data_log.push_back(bus.conf_data);
        hs_cyc = cyc;
      end
    end
    // memory grant
    bus.mem_gnt = 1'b0;
    if (bus.mem_req) begin
      if (req_wait > 0 && bus.mem_addr !== held_addr) addr_bad++;
      held_addr = bus.mem_addr;
      n_req++;
      if (req_wait >= gnt_dly) begin
        bus.mem_gnt = 1'b1; req_wait = 0;
        addr_log.push_back(bus.mem_addr);
        rv_data = memword(bus.mem_addr);
        rv_cnt  = 1 + rv_extra;
        if (rs_mode == 1 && data_log.size() == 1) begin
          chg_req = 1'b1; chg_addr = rs_addr; chg_words = rs_words; rs_mode = 0;
        end
      end else req_wait++;
    end
  endtask

  task automatic run_load(input logic [31:0] a, input logic [15:0] w);
    int k;
    chg_req = 1'b1; chg_addr = a; chg_words = w;
    k = 0;
    while (n_done == 0 && k < 200) begin step(); k++; end
    chk("done_seen", 64'(n_done != 0), 64'd1);
    repeat (4) step();
  endtask

  initial begin
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0; bus.conf_ready = 1'b0;
    cks_word = '0;
    clear();
    repeat (2) @(negedge clk_i);
    chk("rst_req",   64'(bus.mem_req),    64'd0);
    chk("rst_addr",  64'(bus.mem_addr),   64'd0);
    chk("rst_valid", 64'(bus.conf_valid), 64'd0);
    chk("rst_data",  64'(bus.conf_data),  64'd0);
    chk("rst_done",  64'(conf_done),      64'd0);
    chk("rst_busy",  64'(busy),           64'd0);
`ifdef CONF_LOADER_CHECKSUM_EN
    chk("rst_err",   64'(conf_err),       64'd0);
`endif
    rst_ni = 1'b1;
    step();

`ifndef CONF_LOADER_CHECKSUM_EN
    // basic 3-word load, zero-wait memory
    clear();
    run_load(32'h1000, 16'd3);
    chk("t1_nreads", 64'(addr_log.size()), 64'd3);
    chk("t1_a0", 64'(addr_log[0]), 64'h1000);
    chk("t1_a1", 64'(addr_log[1]), 64'h1004);
    chk("t1_a2", 64'(addr_log[2]), 64'h1008);
    chk("t1_nwords", 64'(data_log.size()), 64'd3);
    chk("t1_d0", 64'(data_log[0]), 64'h5A5A_1000);
    chk("t1_d1", 64'(data_log[1]), 64'h5A5A_1004);
    chk("t1_d2", 64'(data_log[2]), 64'h5A5A_1008);
    chk("t1_ndone", 64'(n_done), 64'd1);
    chk("t1_done_after_hs", 64'(done_cyc - hs_cyc), 64'd1);
    chk("t1_latency", 64'(done_cyc - chg_cyc), 64'd10);
    chk("t1_busy_cycles", 64'(n_busy), 64'd10);
    chk("t1_busy_end", 64'(busy), 64'd0);

    // zero-length load: done in the cycle after the change, busy only in DONE
    clear();
    run_load(32'h1500, 16'd0);
    chk("t2_nreq", 64'(n_req), 64'd0);
    chk("t2_latency", 64'(done_cyc - chg_cyc), 64'd1);
    chk("t2_busy_cycles", 64'(n_busy), 64'd1);
    chk("t2_ndone", 64'(n_done), 64'd1);

    // chain stalls the first word for 5 cycles
    clear();
    hold_left = 5;
    run_load(32'h1100, 16'd2);
    chk("t3_hold_stable", 64'(hold_bad), 64'd0);
    chk("t3_req_in_hold", 64'(req_in_hold), 64'd0);
    chk("t3_d0", 64'(data_log[0]), 64'h5A5A_1100);
    chk("t3_d1", 64'(data_log[1]), 64'h5A5A_1104);
    chk("t3_latency", 64'(done_cyc - chg_cyc), 64'd12);

    // grant delayed 4 cycles: request held for 5 cycles with a steady address
    clear();
    gnt_dly = 4;
    run_load(32'h1200, 16'd1);
    chk("t4_req_cycles", 64'(n_req), 64'd5);
    chk("t4_addr_stable", 64'(addr_bad), 64'd0);
    chk("t4_a0", 64'(addr_log[0]), 64'h1200);
    chk("t4_d0", 64'(data_log[0]), 64'h5A5A_1200);
    chk("t4_latency", 64'(done_cyc - chg_cyc), 64'd8);

    // restart while the second read of a 4-word load is in flight
    clear();
    rv_extra = 2; rs_mode = 1; rs_addr = 32'h2000; rs_words = 16'd2;
    run_load(32'h1000, 16'd4);
    chk("t5_nreads", 64'(addr_log.size()), 64'd4);
    chk("t5_a1", 64'(addr_log[1]), 64'h1004);
    chk("t5_a2", 64'(addr_log[2]), 64'h2000);
    chk("t5_a3", 64'(addr_log[3]), 64'h2004);
    chk("t5_nwords", 64'(data_log.size()), 64'd3);
    chk("t5_d1", 64'(data_log[1]), 64'h5A5A_2000);
    chk("t5_d2", 64'(data_log[2]), 64'h5A5A_2004);
    chk("t5_ndone", 64'(n_done), 64'd1);

    // restart while a word waits in PUSH: that word is dropped
    clear();
    hold_left = 3; rs_mode = 2; rs_addr = 32'h2100; rs_words = 16'd1;
    run_load(32'h1000, 16'd3);
    chk("t6_nreads", 64'(addr_log.size()), 64'd2);
    chk("t6_a1", 64'(addr_log[1]), 64'h2100);
    chk("t6_nwords", 64'(data_log.size()), 64'd1);
    chk("t6_d0", 64'(data_log[0]), 64'h5A5A_2100);
    chk("t6_ndone", 64'(n_done), 64'd1);
`else
    // payload A5, 0F with matching checksum AA
    clear();
    cks_word = 32'h0000_00AA;
    run_load(32'h3000, 16'd3);
    chk("c1_nreads", 64'(addr_log.size()), 64'd3);
    chk("c1_nwords", 64'(data_log.size()), 64'd2);
    chk("c1_d0", 64'(data_log[0]), 64'h0000_00A5);
    chk("c1_d1", 64'(data_log[1]), 64'h0000_000F);
    chk("c1_err", 64'(err_at_done), 64'd0);
    chk("c1_ndone", 64'(n_done), 64'd1);

    // same payload, wrong checksum AB
    clear();
    cks_word = 32'h0000_00AB;
    run_load(32'h3000, 16'd3);
    chk("c2_nwords", 64'(data_log.size()), 64'd2);
    chk("c2_d1", 64'(data_log[1]), 64'h0000_000F);
    chk("c2_err", 64'(err_at_done), 64'd1);
    chk("c2_err_sticky", 64'(conf_err), 64'd1);
    chk("c2_ndone", 64'(n_done), 64'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
